// File: rtl/rom_load_ctrl.sv
// ioctl download sequencer: routes ROM/DIP/mode bytes to core storage, holds the
// core in reset through ROM load plus a settle window, and reports load statistics.
module rom_load_ctrl #(
    parameter logic [15:0] PROG_BASE     = 16'h0000,
    parameter logic [16:0] PROG_SIZE     = 17'h0C000,
    parameter logic [15:0] VEC_BASE      = 16'hC000,
    parameter logic [16:0] VEC_SIZE      = 17'h04000,
    parameter logic [16:0] TOTAL_BYTES   = 17'h10000,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic        clk_25,
    input  logic        RESET_L,
    input  logic        dn_download,
    input  logic [7:0]  dn_index,
    input  logic        dn_wr,
    input  logic [24:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic        prog_we,
    output logic        vec_we,
    output logic [15:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        dip_we,
    output logic [2:0]  dip_sel,
    output logic [7:0]  dip_data,
    output logic [7:0]  mode,
    output logic        core_reset_l,
    output logic        load_busy,
    output logic        load_ok,
    output logic [7:0]  load_sum,
    output logic [16:0] byte_cnt
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    localparam logic [7:0] IDX_ROM  = 8'd0;
    localparam logic [7:0] IDX_MODE = 8'd1;
    localparam logic [7:0] IDX_DIP  = 8'd254;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;

    logic          rom_start;
    logic          rom_wr;
    logic          dip_wr;
    logic          mode_wr;
    logic          addr_hi_zero;
    logic [17:0]   a18;
    logic [17:0]   prog_off;
    logic [17:0]   vec_off;
    logic          in_prog;
    logic          in_vec;
    logic [16:0]   byte_cnt_nxt;
    logic [7:0]    load_sum_nxt;

    // Offsets below the region base wrap to huge values, so one unsigned
    // compare against the size covers both window bounds.
    always_comb begin
        rom_start    = dn_download && (dn_index == IDX_ROM);
        rom_wr       = (state == LOAD) && dn_wr && (dn_index == IDX_ROM);
        dip_wr       = dn_wr && (dn_index == IDX_DIP) && (dn_addr[24:3] == '0);
        mode_wr      = dn_wr && (dn_index == IDX_MODE);
        addr_hi_zero = (dn_addr[24:16] == '0);
        a18          = {2'b00, dn_addr[15:0]};
        prog_off     = a18 - {2'b00, PROG_BASE};
        vec_off      = a18 - {2'b00, VEC_BASE};
        in_prog      = addr_hi_zero && (prog_off < {1'b0, PROG_SIZE});
        in_vec       = addr_hi_zero && !in_prog && (vec_off < {1'b0, VEC_SIZE});

        byte_cnt_nxt = byte_cnt;
        load_sum_nxt = load_sum;
        if (rom_wr) begin
            if (byte_cnt != '1) begin
                byte_cnt_nxt = byte_cnt + 17'd1;
            end
            load_sum_nxt = load_sum + dn_data;
        end
    end

    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            byte_cnt     <= '0;
            load_sum     <= '0;
            load_ok      <= 1'b0;
            load_busy    <= 1'b0;
            core_reset_l <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    byte_cnt <= byte_cnt_nxt;
                    load_sum <= load_sum_nxt;
                    if (!dn_download) begin
                        state      <= SETTLE;
                        load_ok    <= (byte_cnt_nxt == TOTAL_BYTES);
                        settle_cnt <= SETTLE_LAST;
                    end
                end
                default: begin
                    if (rom_start) begin
                        state        <= LOAD;
                        byte_cnt     <= '0;
                        load_sum     <= '0;
                        load_ok      <= 1'b0;
                        settle_cnt   <= '0;
                        load_busy    <= 1'b1;
                        core_reset_l <= 1'b0;
                    end else if (state == SETTLE) begin
                        if (settle_cnt == '0) begin
                            state        <= RUN;
                            load_busy    <= 1'b0;
                            core_reset_l <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt - CW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Data/address outputs hold their last value; only the enables pulse.
    always_ff @(posedge clk_25 or negedge RESET_L) begin
        if (!RESET_L) begin
            prog_we  <= 1'b0;
            vec_we   <= 1'b0;
            rom_addr <= '0;
            rom_data <= '0;
            dip_we   <= 1'b0;
            dip_sel  <= '0;
            dip_data <= '0;
            mode     <= '0;
        end else begin
            prog_we <= rom_wr && in_prog;
            vec_we  <= rom_wr && in_vec;
            if (rom_wr && (in_prog || in_vec)) begin
                rom_addr <= in_prog ? prog_off[15:0] : vec_off[15:0];
                rom_data <= dn_data;
            end

            dip_we <= dip_wr;
            if (dip_wr) begin
                dip_sel  <= dn_addr[2:0];
                dip_data <= dn_data;
            end

            if (mode_wr) begin
                mode <= dn_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Self-checking bench for rom_load_ctrl: directed scenarios plus a randomized
// byte stream compared against an address-map reference model.
module tb_rom_load_ctrl;

    localparam int unsigned SETTLE = 64;
    localparam int PROG_LO = 'h0000;
    localparam int PROG_SZ = 'hC000;
    localparam int VEC_LO  = 'hC000;
    localparam int VEC_SZ  = 'h4000;
    localparam int TOTAL   = 65536;

    logic        clk_25 = 1'b0;
    logic        RESET_L = 1'b1;
    logic        dn_download = 1'b0;
    logic [7:0]  dn_index = '0;
    logic        dn_wr = 1'b0;
    logic [24:0] dn_addr = '0;
    logic [7:0]  dn_data = '0;
    logic        prog_we, vec_we, dip_we, core_reset_l, load_busy, load_ok;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data, dip_data, mode, load_sum;
    logic [2:0]  dip_sel;
    logic [16:0] byte_cnt;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_mode = '0;

    rom_load_ctrl #(
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_25(clk_25), .RESET_L(RESET_L), .dn_download(dn_download),
        .dn_index(dn_index), .dn_wr(dn_wr), .dn_addr(dn_addr), .dn_data(dn_data),
        .prog_we(prog_we), .vec_we(vec_we), .rom_addr(rom_addr), .rom_data(rom_data),
        .dip_we(dip_we), .dip_sel(dip_sel), .dip_data(dip_data), .mode(mode),
        .core_reset_l(core_reset_l), .load_busy(load_busy), .load_ok(load_ok),
        .load_sum(load_sum), .byte_cnt(byte_cnt)
    );

    always #20 clk_25 = ~clk_25;

    // Reference address map: which region a download address lands in and where.
    function automatic void exp_rom(input logic [24:0] addr, output logic p,
                                    output logic v, output logic [15:0] off);
        int a;
        a = int'(addr);
        p = 1'b0;
        v = 1'b0;
        off = '0;
        if (a >= PROG_LO && a < PROG_LO + PROG_SZ) begin
            p = 1'b1;
            off = 16'(a - PROG_LO);
        end else if (a >= VEC_LO && a < VEC_LO + VEC_SZ) begin
            v = 1'b1;
            off = 16'(a - VEC_LO);
        end
    endfunction

    task automatic start_rom();
        @(negedge clk_25);
        dn_download = 1'b1;
        dn_index = 8'd0;
        dn_wr = 1'b0;
        @(negedge clk_25);
    endtask

    // Counts rising clock edges until core_reset_l goes high.
    task automatic wait_release(input int already, input string nm);
        int n;
        n = already;
        while (core_reset_l !== 1'b1 && n < int'(SETTLE) + 50) begin
            @(posedge clk_25);
            #1;
            n++;
        end
        total++;
        if (n != int'(SETTLE) + 1) begin
            bad++;
            $display("FAIL %s: release after %0d clocks, expected %0d", nm, n, SETTLE + 1);
        end
        total++;
        if (load_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy: load_busy=%b expected 0", nm, load_busy);
        end
    endtask

    task automatic test_reset();
        logic [73:0] all_out;
        #1 RESET_L = 1'b0;
        #5;
        all_out = {prog_we, vec_we, rom_addr, rom_data, dip_we, dip_sel, dip_data, mode,
                   core_reset_l, load_busy, load_ok, load_sum, byte_cnt};
        total++;
        if (all_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        @(negedge clk_25);
        RESET_L = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_25);
            #1;
            total++;
            if ({prog_we, vec_we, dip_we, core_reset_l, load_busy} !== 5'b0) begin
                bad++;
                $display("FAIL idle_hold: got %b expected 00000",
                         {prog_we, vec_we, dip_we, core_reset_l, load_busy});
            end
        end
    endtask

    task automatic test_full_load();
        logic p, v;
        logic [15:0] off;
        start_rom();
        total++;
        if ({load_busy, core_reset_l} !== 2'b10) begin
            bad++;
            $display("FAIL full_enter: busy/core_rst got %b expected 10", {load_busy, core_reset_l});
        end
        for (int i = 0; i < TOTAL; i++) begin
            @(negedge clk_25);
            dn_wr = 1'b1;
            dn_addr = 25'(i);
            dn_data = 8'(i);
            if (i == TOTAL - 1) dn_download = 1'b0;
            @(posedge clk_25);
            #1;
            exp_rom(dn_addr, p, v, off);
            total++;
            if ({prog_we, vec_we, rom_addr, rom_data} !== {p, v, off, dn_data}) begin
                bad++;
                $display("FAIL full_write: addr %h got %h expected %h", dn_addr,
                         {prog_we, vec_we, rom_addr, rom_data}, {p, v, off, dn_data});
            end
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        @(posedge clk_25);
        #1;
        total++;
        if ({prog_we, vec_we, core_reset_l, load_busy, load_ok, load_sum, byte_cnt} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 17'h10000}) begin
            bad++;
            $display("FAIL full_stats: ok=%b sum=%h cnt=%h we=%b%b", load_ok, load_sum,
                     byte_cnt, prog_we, vec_we);
        end
        wait_release(2, "full_release");
    endtask

    task automatic test_short_load();
        logic [7:0] sum;
        sum = '0;
        start_rom();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_25);
            dn_wr = 1'b1;
            dn_addr = 25'(i);
            dn_data = 8'($urandom);
            sum = sum + dn_data;
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_download = 1'b0;
        wait_release(0, "short_release");
        total++;
        if ({load_ok, load_sum, byte_cnt} !== {1'b0, sum, 17'd100}) begin
            bad++;
            $display("FAIL short_stats: ok=%b sum=%h cnt=%0d expected 0 %h 100",
                     load_ok, load_sum, byte_cnt, sum);
        end
    endtask

    task automatic test_dip();
        logic [7:0] d;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_25);
            d = 8'($urandom);
            dn_index = 8'd254;
            dn_addr = 25'(k);
            dn_data = d;
            dn_wr = 1'b1;
            @(posedge clk_25);
            #1;
            total++;
            if ({dip_we, dip_sel, dip_data, core_reset_l} !== {1'b1, 3'(k), d, 1'b1}) begin
                bad++;
                $display("FAIL dip_write: got %h expected %h",
                         {dip_we, dip_sel, dip_data, core_reset_l}, {1'b1, 3'(k), d, 1'b1});
            end
        end
        @(negedge clk_25);
        dn_addr = 25'd8;
        @(posedge clk_25);
        #1;
        total++;
        if (dip_we !== 1'b0) begin
            bad++;
            $display("FAIL dip_addr8: dip_we=%b expected 0", dip_we);
        end
        @(negedge clk_25);
        dn_index = 8'd0;
        dn_addr = 25'd5;
        @(posedge clk_25);
        #1;
        total++;
        if ({prog_we, vec_we, core_reset_l, byte_cnt} !== {1'b0, 1'b0, 1'b1, 17'd100}) begin
            bad++;
            $display("FAIL rom_wr_idle: we=%b%b core=%b cnt=%0d expected 00 1 100",
                     prog_we, vec_we, core_reset_l, byte_cnt);
        end
        @(negedge clk_25);
        dn_index = 8'd7;
        @(posedge clk_25);
        #1;
        total++;
        if ({prog_we, vec_we, dip_we, mode} !== {3'b000, exp_mode}) begin
            bad++;
            $display("FAIL other_index: got %h expected %h", {prog_we, vec_we, dip_we, mode},
                     {3'b000, exp_mode});
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_index = 8'd0;
    endtask

    task automatic test_mode();
        logic [7:0] vals [2];
        vals[0] = 8'h02;
        vals[1] = 8'h03;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_25);
            dn_index = 8'd1;
            dn_data = vals[k];
            dn_wr = 1'b1;
            exp_mode = vals[k];
            @(posedge clk_25);
            #1;
            total++;
            if ({mode, core_reset_l} !== {exp_mode, 1'b1}) begin
                bad++;
                $display("FAIL mode_write: mode=%h core=%b expected %h 1", mode, core_reset_l,
                         exp_mode);
            end
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_index = 8'd0;
    endtask

    task automatic test_settle_restart();
        logic [7:0] sum;
        start_rom();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_25);
            dn_wr = 1'b1;
            dn_addr = 25'(i);
            dn_data = 8'($urandom);
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_download = 1'b0;
        repeat (SETTLE / 2) @(posedge clk_25);
        #1;
        total++;
        if ({core_reset_l, load_busy, byte_cnt} !== {1'b0, 1'b1, 17'd10}) begin
            bad++;
            $display("FAIL mid_settle: core=%b busy=%b cnt=%0d expected 0 1 10",
                     core_reset_l, load_busy, byte_cnt);
        end
        @(negedge clk_25);
        dn_download = 1'b1;
        @(posedge clk_25);
        #1;
        total++;
        if ({byte_cnt, load_sum, load_ok, load_busy, core_reset_l} !== {17'd0, 8'd0, 3'b010}) begin
            bad++;
            $display("FAIL restart_clear: cnt=%0d sum=%h ok=%b busy=%b core=%b",
                     byte_cnt, load_sum, load_ok, load_busy, core_reset_l);
        end
        sum = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_25);
            dn_wr = 1'b1;
            dn_addr = 25'('hC000 + i);
            dn_data = 8'($urandom);
            sum = sum + dn_data;
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_download = 1'b0;
        wait_release(0, "restart_release");
        total++;
        if ({byte_cnt, load_sum} !== {17'd5, sum}) begin
            bad++;
            $display("FAIL restart_stats: cnt=%0d sum=%h expected 5 %h", byte_cnt, load_sum, sum);
        end
    endtask

    task automatic test_random();
        logic [7:0]  idx_tab [6];
        logic [15:0] edge_tab [4];
        logic        wr, p, v, dp, en;
        logic [7:0]  idx;
        logic [24:0] addr;
        logic [15:0] off;
        logic [7:0]  d, m_sum;
        int          m_cnt;
        int          sel;
        logic [43:0] obs, expv;
        idx_tab = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd254, 8'd7};
        edge_tab = '{16'hBFFF, 16'hC000, 16'hFFFF, 16'h0000};
        m_sum = '0;
        m_cnt = 0;
        start_rom();
        for (int i = 0; i < 400; i++) begin
            wr = ($urandom_range(3) != 0);
            idx = idx_tab[$urandom_range(5)];
            sel = int'($urandom_range(7));
            if (sel == 5) addr = 25'($urandom_range(15));
            else if (sel == 6) addr = 25'($urandom) | 25'h10000;
            else if (sel == 7) addr = {9'd0, edge_tab[$urandom_range(3)]};
            else addr = {9'd0, 16'($urandom)};
            d = 8'($urandom);
            @(negedge clk_25);
            dn_wr = wr;
            dn_index = idx;
            dn_addr = addr;
            dn_data = d;
            p = 1'b0;
            v = 1'b0;
            off = '0;
            if (wr && idx == 8'd0) begin
                exp_rom(addr, p, v, off);
                m_cnt++;
                m_sum = m_sum + d;
            end
            dp = wr && idx == 8'd254 && int'(addr) < 8;
            if (wr && idx == 8'd1) exp_mode = d;
            @(posedge clk_25);
            #1;
            en = p | v;
            obs  = {prog_we, vec_we, en ? rom_addr : 16'h0, en ? rom_data : 8'h0,
                    dip_we, dp ? dip_sel : 3'h0, dp ? dip_data : 8'h0, mode};
            expv = {p, v, off, en ? d : 8'h0, dp, dp ? addr[2:0] : 3'h0, dp ? d : 8'h0,
                    exp_mode};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random_cycle %0d: idx=%0d addr=%h got %h expected %h",
                         i, idx, addr, obs, expv);
            end
        end
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_index = 8'd0;
        dn_download = 1'b0;
        @(posedge clk_25);
        #1;
        total++;
        if ({byte_cnt, load_sum, load_ok} !== {17'(m_cnt), m_sum, 1'b0}) begin
            bad++;
            $display("FAIL random_stats: cnt=%0d sum=%h ok=%b expected %0d %h 0",
                     byte_cnt, load_sum, load_ok, m_cnt, m_sum);
        end
        wait_release(1, "random_release");
    endtask

    task automatic test_reset_mid_load();
        logic rose;
        start_rom();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_25);
            dn_wr = 1'b1;
            dn_addr = 25'(i);
            dn_data = 8'($urandom);
        end
        #5 RESET_L = 1'b0;
        #1;
        total++;
        if ({core_reset_l, load_busy, load_ok, byte_cnt, load_sum, prog_we, vec_we, mode} !== '0) begin
            bad++;
            $display("FAIL async_reset: core=%b busy=%b cnt=%0d sum=%h we=%b%b mode=%h",
                     core_reset_l, load_busy, byte_cnt, load_sum, prog_we, vec_we, mode);
        end
        exp_mode = '0;
        @(negedge clk_25);
        dn_wr = 1'b0;
        dn_download = 1'b0;
        RESET_L = 1'b1;
        rose = 1'b0;
        for (int i = 0; i < 3 * int'(SETTLE); i++) begin
            @(posedge clk_25);
            #1;
            if (core_reset_l !== 1'b0 || load_busy !== 1'b0) rose = 1'b1;
        end
        total++;
        if (rose !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: core left reset or busy, expected held in IDLE");
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short_load();
        test_dip();
        test_mode();
        test_settle_restart();
        test_random();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the HPS ioctl download stream into the arcade core's storage:
  - program ROM and vector ROM write ports;
  - the 8×8 DIP bank;
  - the game-mode register.
- Holds the CPU/vector core in reset while ROM contents are changing, and for a settle window afterwards.
- Reports a byte count, an additive checksum and a load-OK flag for the ROM image.
- Sits between hps_io and the core top (BWIDOW_TOP-class), replacing ad-hoc download decode in the emu wrapper.

Parameters:
- PROG_BASE, 16'h0000, first download address of the program ROM region
- PROG_SIZE, 17'h0C000, program ROM region size in bytes
- VEC_BASE, 16'hC000, first download address of the vector ROM region
- VEC_SIZE, 17'h04000, vector ROM region size in bytes
- TOTAL_BYTES, 17'h10000, expected ROM image length for load_ok
- SETTLE_CYCLES, 1024, clocks core reset is held after ROM download ends (≥1)

Ports:
- clk_25  in  1  system clock
- RESET_L  in  1  asynchronous active-low reset
- dn_download  in  1  ioctl download active
- dn_index  in  8  ioctl index (0 = ROM, 1 = mode, 254 = DIP)
- dn_wr  in  1  ioctl write strobe, one cycle per byte
- dn_addr  in  25  ioctl byte address
- dn_data  in  8  ioctl byte
- prog_we  out  1  program ROM write enable
- vec_we  out  1  vector ROM write enable
- rom_addr  out  16  region-local write offset
- rom_data  out  8  write data
- dip_we  out  1  DIP byte write enable
- dip_sel  out  3  DIP byte index
- dip_data  out  8  DIP byte
- mode  out  8  game mode value (0 bwidow, 1 gravitar, 2 lunarbat, 3 spacduel)
- core_reset_l  out  1  active-low reset to core
- load_busy  out  1  high in LOAD or SETTLE
- load_ok  out  1  last ROM load received exactly TOTAL_BYTES bytes
- load_sum  out  8  mod-256 sum of last ROM image
- byte_cnt  out  17  bytes written in current/last ROM load

Behaviour:
- Reset (RESET_L low, async):
  - state = IDLE;
  - all write enables, dip_sel, dip_data, rom_addr, rom_data, mode, load_sum, byte_cnt, load_ok, load_busy = 0;
  - core_reset_l = 0.
- States:
  - IDLE: core held in reset, no ROM yet.
  - LOAD: ROM download in progress.
  - SETTLE: post-load hold.
  - RUN: core released.
- ROM start: rom_start = dn_download & dn_index==0.
  - IDLE/RUN/SETTLE → LOAD when rom_start.
  - On that entry cycle: byte_cnt, load_sum, load_ok and the settle counter are cleared.
- LOAD → SETTLE the first cycle dn_download is low.
  - On that cycle: load_ok <= (byte_cnt == TOTAL_BYTES), including a byte written that same cycle.
  - The settle counter loads SETTLE_CYCLES-1.
- SETTLE: counts down 1 per clock; → RUN on the cycle after the counter reaches 0.
  - core_reset_l rises when RUN is entered.
  - rom_start during SETTLE restarts LOAD; the counter is discarded.
- RUN: core_reset_l = 1, load_busy = 0.
- core_reset_l = 0 in IDLE, LOAD and SETTLE. load_busy = 1 in LOAD and SETTLE.
- ROM writes (index 0, dn_wr, state LOAD):
  - Address window: a = dn_addr[15:0], and dn_addr[24:16] must be 0.
  - a in [PROG_BASE, PROG_BASE+PROG_SIZE) → prog_we, rom_addr = a - PROG_BASE.
  - Else a in [VEC_BASE, VEC_BASE+VEC_SIZE) → vec_we, rom_addr = a - VEC_BASE.
  - Else no write enable.
  - Latency: 1 registered cycle from dn_wr. Enables are single-cycle pulses, never both high.
  - Every ROM-index byte, in-region or not:
    - byte_cnt +1, saturating at 17'h1FFFF;
    - load_sum += dn_data, wrapping mod 256.
- DIP writes (index 254, dn_wr, dn_addr[24:3]==0): one cycle later, dip_we = 1, dip_sel = dn_addr[2:0], dip_data = dn_data.
  - Accepted in any state; the core is not reset.
  - Writes with higher addresses are ignored.
- Mode writes (index 1, dn_wr): mode <= dn_data, last write wins.
  - Accepted in any state; the core is not reset.
- dn_wr with any other index: no effect.
- dn_wr while index 0 and state ≠ LOAD (strobe arriving with download already low): ignored.
- Reset mid-LOAD: returns to IDLE and clears all counters. The core stays in reset until a new complete ROM load plus settle.

Test Plan:
- Reset, then no download → core_reset_l=0, state IDLE, all enables 0 indefinitely.
- ROM load of 65536 bytes, data = addr[7:0]:
  - prog_we for offsets 0..0xBFFF; vec_we with rom_addr 0..0x3FFF for addr 0xC000..0xFFFF;
  - byte_cnt=65536, load_sum=8'h00, load_ok=1;
  - core_reset_l rises exactly SETTLE_CYCLES+1 clocks after dn_download falls.
- Short ROM load of 100 bytes → load_ok=0, byte_cnt=100, core still released after settle.
- DIP write sequence addr 0..7 (index 254) while in RUN:
  - eight dip_we pulses with matching dip_sel/dip_data, core_reset_l stays 1;
  - addr 8 produces no pulse.
- Mode write of 8'h02 (index 1) → mode=2 next cycle, core_reset_l unchanged.
- New ROM download started mid-SETTLE, and separately RESET_L pulsed mid-LOAD:
  - settle restarts from LOAD, counters cleared;
  - async reset forces IDLE immediately, core_reset_l=0.
